player_sprite_reader: RTL and testbench
=======================================

# player_sprite_reader

Raster-side read engine for the player sprite RAM. From the VGA controller's current pixel coordinate and the player's position, it generates the sprite RAM read address. It then returns the fetched palette index, aligned with a pipeline-delayed pixel-hit flag, to the color mapper. Position and visibility are shadowed once per frame to prevent tearing. Optional multi-frame animation selects the frame base address.

## Interface
- SPR_W, 24, sprite width in pixels
- SPR_H, 30, sprite height in pixels
- NUM_FRAMES, 2, frames stored back-to-back in RAM (SPR_W*SPR_H*NUM_FRAMES ≤ 1440)
- FRAME_HOLD, 8, video frames per animation step
- INIT_X, 308, reset shadow X
- INIT_Y, 440, reset shadow Y
- Clk  in  1  system/pixel clock; one clock domain only
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pos_x  in  10  player top-left X; sampled on frame_start
- pos_y  in  10  player top-left Y; sampled on frame_start
- visible  in  1  sprite enable; sampled on frame_start
- read_address  out  19  registered sprite RAM read address
- rd_data  in  5  RAM data_Out; bits [2:0] are the palette index, bits [4:3] are ignored
- pixel_on  out  1  sprite pixel present and opaque at the delayed coordinate
- pixel_idx  out  3  palette index; 0 whenever pixel_on=0

## Operation
- Shadow registers sx, sy, svis load pos_x, pos_y, visible on any cycle with frame_start=1. They hold their value at all other times.
- Hit test at stage 0 (combinational on DrawX/DrawY):
  - hit = svis & DrawX≥sx & DrawX<sx+SPR_W & DrawY≥sy & DrawY<sy+SPR_H.
  - All bounds are computed in 11-bit unsigned arithmetic, so sx+SPR_W>1023 cannot wrap. Sprites extending past the screen edge clip naturally.
- Address:
  - dx = DrawX−sx and dy = DrawY−sy, both truncated to 10 bits.
  - addr = base + dy*SPR_W + dx, zero-extended to 19 bits.
  - base = frame*SPR_W*SPR_H.
  - On a miss, read_address keeps its previous value, which limits RAM toggling.
- Stage 1: register read_address and hit1.
- Stage 2: register hit2 = hit1. The RAM returns rd_data in this same cycle.
- Output stage (combinational from hit2 and rd_data):
  - pixel_on = hit2 & (rd_data[2:0]≠0). Palette index 0 is transparent.
  - pixel_idx = pixel_on ? rd_data[2:0] : 0.
- Reset values: read_address=0, hit1=hit2=0, pixel_on=0, pixel_idx=0, sx=INIT_X, sy=INIT_Y, svis=1, frame=0, hold count=0.
- Reset asserted mid-line flushes the pipeline. pixel_on is 0 starting the cycle after Reset is sampled.
- frame_start arriving in the same cycle as a hit uses the old shadow values for that pixel. The new values apply from the next cycle.

## Timing
- DrawX/DrawY at cycle N → read_address valid at N+1 → pixel_on/pixel_idx valid at N+2. The fixed latency is 2 cycles.
- The downstream mapper must delay DrawX/DrawY by 2 cycles to match.
- The block needs no stall, handshake or backpressure. Throughput is one pixel per clock.
- The frame counter advances only on frame_start, never within a frame.

## Configuration
- Macro: SPRITE_ANIM_EN.
- Defined:
  - hold counter counts frame_start pulses 0..FRAME_HOLD−1.
  - On the pulse where hold=FRAME_HOLD−1, hold returns to 0 and frame increments.
  - frame wraps from NUM_FRAMES−1 to 0.
  - base = frame*SPR_W*SPR_H.
- Undefined: frame and hold counter are absent, and base=0, so only frame 0 is ever read.

## Structure
- Package sprite_pkg holds:
  - SCREEN_W=640, SCREEN_H=480;
  - typedef coord_t (logic [9:0]);
  - typedef sprite_addr_t (logic [18:0]);
  - typedef pal_idx_t (logic [2:0]).
- One sub-module: sprite_anim_ctr (hold counter plus frame counter). It is instantiated only under SPRITE_ANIM_EN.

## Test plan
- Reset, then scan the full 640×480 frame with the RAM model zero-filled → pixel_on stays 0 throughout; read_address=0 after reset.
- Run a 2-frame scan:
  - Frame 1 setup: frame_start with pos=(100,200), visible=1. RAM entry 0=3 and entry 24*29+23=5.
  - DrawX=100, DrawY=200 at N → read_address=0 at N+1; pixel_on=1, pixel_idx=3 at N+2.
  - DrawX=123, DrawY=229 → read_address=719, pixel_idx=5.
  - DrawX=124 → pixel_on=0.
- Edge clip: pos=(630,470) → hits only for X 630..639 and Y 470..479; DrawX=639, DrawY=479 gives address 9*24+9=225.
- Tearing: change pos_x mid-frame without frame_start → hit region unchanged until the next frame_start pulse.
- Transparency and visibility: RAM entry=0 inside the box → pixel_on=0, pixel_idx=0. visible=0 latched → no hits anywhere.
- With SPRITE_ANIM_EN, FRAME_HOLD=8: after 8 frame_start pulses, the sprite origin reads address 720; after 16 pulses, it reads 0 again. Reset mid-scan → pixel_on=0 next cycle and frame=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen constants and types for the player sprite read path.
// Build option: SPRITE_ANIM_EN enables multi-frame animation in player_sprite_reader.
package sprite_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    typedef logic [9:0]  coord_t;
    typedef logic [18:0] sprite_addr_t;
    typedef logic [2:0]  pal_idx_t;
    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr: animation step counter for the player sprite.
// Ports:
//   Clk, Reset      - clock, synchronous active-high reset
//   i_frame_start   - one-cycle pulse per video frame
//   o_frame         - current animation frame, 0..NUM_FRAMES-1
// Counts FRAME_HOLD frame_start pulses per animation step, then advances o_frame (wrapping).
// Used by player_sprite_reader only when SPRITE_ANIM_EN is defined.
module sprite_anim_ctr import sprite_pkg::*; #(
    parameter int FRAME_HOLD = 8,
    parameter int NUM_FRAMES = 2,
    parameter int FW         = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_frame_start,
    output logic [FW-1:0] o_frame
);
    localparam int HW = cnt_w(FRAME_HOLD);
    logic [HW-1:0] r_hold;
    logic [FW-1:0] r_frame;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold  <= '0;
            r_frame <= '0;
        end else if (i_frame_start) begin
            if (r_hold == HW'(FRAME_HOLD - 1)) begin
                r_hold  <= '0;
                r_frame <= (r_frame == FW'(NUM_FRAMES - 1)) ? '0 : r_frame + FW'(1);
            end else begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end
    assign o_frame = r_frame;
endmodule

// File: rtl/player_sprite_reader.sv
// player_sprite_reader: raster-side read engine for the player sprite RAM.
// Ports:
//   Clk, Reset            - pixel clock, synchronous active-high reset
//   frame_start           - one-cycle pulse at start of vertical blank; loads shadows
//   DrawX, DrawY          - current raster coordinate
//   pos_x, pos_y, visible - player position/enable, shadowed on frame_start
//   read_address          - registered sprite RAM address (valid 1 cycle after DrawX/DrawY)
//   rd_data               - RAM data; [2:0] palette index, [4:3] ignored
//   pixel_on, pixel_idx   - opaque-hit flag and palette index (2 cycles after DrawX/DrawY)
// Build option: define SPRITE_ANIM_EN to cycle through NUM_FRAMES stored sprite frames.
module player_sprite_reader import sprite_pkg::*; #(
    parameter int SPR_W      = 24,
    parameter int SPR_H      = 30,
    parameter int NUM_FRAMES = 2,
    parameter int FRAME_HOLD = 8,
    parameter int INIT_X     = 308,
    parameter int INIT_Y     = 440
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_start,
    input  coord_t       DrawX,
    input  coord_t       DrawY,
    input  coord_t       pos_x,
    input  coord_t       pos_y,
    input  logic         visible,
    output sprite_addr_t read_address,
    input  logic [4:0]   rd_data,
    output logic         pixel_on,
    output pal_idx_t     pixel_idx
);
    coord_t       r_sx, r_sy;
    logic         r_svis;
    sprite_addr_t r_addr;
    logic         r_hit1, r_hit2;
    logic         w_hit;
    coord_t       w_dx, w_dy;
    sprite_addr_t w_base, w_addr;
    logic         w_unused_rd;
    // Bounds in 11 bits so a sprite near X/Y=1023 clips instead of wrapping.
    assign w_hit = r_svis
                && ({1'b0, DrawX} >= {1'b0, r_sx}) && ({1'b0, DrawX} < {1'b0, r_sx} + 11'(SPR_W))
                && ({1'b0, DrawY} >= {1'b0, r_sy}) && ({1'b0, DrawY} < {1'b0, r_sy} + 11'(SPR_H));
    assign w_dx = DrawX - r_sx;
    assign w_dy = DrawY - r_sy;
`ifdef SPRITE_ANIM_EN
    localparam int FW = cnt_w(NUM_FRAMES);
    logic [FW-1:0] w_frame;
    sprite_anim_ctr #(
        .FRAME_HOLD (FRAME_HOLD),
        .NUM_FRAMES (NUM_FRAMES),
        .FW         (FW)
    ) u_anim (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_frame_start (frame_start),
        .o_frame       (w_frame)
    );
    assign w_base = sprite_addr_t'(w_frame) * sprite_addr_t'(SPR_W * SPR_H);
`else
    assign w_base = '0;
`endif
    assign w_addr = w_base + sprite_addr_t'(w_dy) * sprite_addr_t'(SPR_W) + sprite_addr_t'(w_dx);
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sx   <= coord_t'(INIT_X);
            r_sy   <= coord_t'(INIT_Y);
            r_svis <= 1'b1;
            r_addr <= '0;
            r_hit1 <= 1'b0;
            r_hit2 <= 1'b0;
        end else begin
            // The pixel in this cycle still tests against the old shadows.
            if (frame_start) begin
                r_sx   <= pos_x;
                r_sy   <= pos_y;
                r_svis <= visible;
            end
            // Holding the address on a miss keeps the RAM address bus quiet.
            if (w_hit)
                r_addr <= w_addr;
            r_hit1 <= w_hit;
            r_hit2 <= r_hit1;
        end
    end
    assign read_address = r_addr;
    assign pixel_on     = r_hit2 && (rd_data[2:0] != 3'd0);
    assign pixel_idx    = pixel_on ? rd_data[2:0] : 3'd0;
    assign w_unused_rd  = ^rd_data[4:3];
endmodule

// File: tb/tb_player_sprite_reader.sv
// tb_player_sprite_reader: scoreboard bench for player_sprite_reader with a behavioural sprite model.
module tb_player_sprite_reader;
    import sprite_pkg::*;
    localparam int SPR_W = 24, SPR_H = 30, NF = 2, HOLD = 8, IX = 308, IY = 440;
    logic         Clk = 0, Reset = 1, frame_start = 0, visible = 0;
    coord_t       DrawX = 0, DrawY = 0, pos_x = 0, pos_y = 0;
    sprite_addr_t read_address;
    logic [4:0]   rd_data;
    logic         pixel_on;
    pal_idx_t     pixel_idx;
    player_sprite_reader dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .visible      (visible),
        .read_address (read_address),
        .rd_data      (rd_data),
        .pixel_on     (pixel_on),
        .pixel_idx    (pixel_idx)
    );
    always #5 Clk = ~Clk;
    logic [4:0] mem [0:1439];
    always @(posedge Clk) rd_data <= (read_address < 19'd1440) ? mem[read_address] : 5'd0;
    typedef struct {
        int           due;
        sprite_addr_t addr;
        logic         on;
        pal_idx_t     idx;
    } exp_t;
    exp_t qa[$], qp[$];
    int cyc = 0, checks = 0, errors = 0;
    int sx = IX, sy = IY, frame = 0;
    bit svis = 1;
    sprite_addr_t last = 0;
`ifdef SPRITE_ANIM_EN
    int hold = 0;
`endif
    initial forever begin
        @(posedge Clk);
        cyc++;
    end
    initial forever begin
        exp_t e;
        @(negedge Clk);
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            checks++;
            if (read_address !== e.addr) begin
                errors++;
                $display("FAIL read_address cyc=%0d got=%0d exp=%0d", cyc, read_address, e.addr);
            end
        end
        while (qp.size() > 0 && qp[0].due <= cyc) begin
            e = qp.pop_front();
            checks++;
            if (pixel_on !== e.on || pixel_idx !== e.idx) begin
                errors++;
                $display("FAIL pixel cyc=%0d got on=%0b idx=%0d exp on=%0b idx=%0d",
                         cyc, pixel_on, pixel_idx, e.on, e.idx);
            end
        end
    end
    // One raster cycle: drive inputs, predict outputs from the sprite rules, advance the clock.
    task automatic step(input int x, input int y, input bit fs, input int px, input int py,
                        input bit vis, input bit rst);
        bit         hit;
        logic [4:0] w;
        pal_idx_t   pal;
        DrawX = coord_t'(x); DrawY = coord_t'(y); frame_start = fs;
        pos_x = coord_t'(px); pos_y = coord_t'(py); visible = vis; Reset = rst;
        if (rst) begin
            foreach (qp[i]) if (qp[i].due > cyc) begin qp[i].on = 0; qp[i].idx = 0; end
            sx = IX; sy = IY; svis = 1; frame = 0; last = 0;
`ifdef SPRITE_ANIM_EN
            hold = 0;
`endif
            qa.push_back('{cyc + 1, 19'd0, 1'b0, 3'd0});
            qp.push_back('{cyc + 2, 19'd0, 1'b0, 3'd0});
        end else begin
            hit = svis && x >= sx && x < sx + SPR_W && y >= sy && y < sy + SPR_H;
            if (hit) last = sprite_addr_t'(frame * SPR_W * SPR_H + (y - sy) * SPR_W + (x - sx));
            w = mem[last];
            pal = hit ? w[2:0] : 3'd0;
            qa.push_back('{cyc + 1, last, 1'b0, 3'd0});
            qp.push_back('{cyc + 2, 19'd0, pal != 3'd0, pal});
            if (fs) begin
                sx = px; sy = py; svis = vis;
`ifdef SPRITE_ANIM_EN
                if (hold == HOLD - 1) begin hold = 0; frame = (frame + 1) % NF; end
                else hold++;
`endif
            end
        end
        @(posedge Clk); #1;
    endtask
    task automatic px_at(input int x, input int y);
        step(x, y, 0, 0, 0, 1, 0);
    endtask
    task automatic new_frame(input int px, input int py, input bit vis);
        step(1023, 1023, 1, px, py, vis, 0);
    endtask
    task automatic flush();
        repeat (3) px_at(1023, 1023);
    endtask
    task automatic fill_random();
        flush();
        for (int i = 0; i < 1440; i++) mem[i] = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
    endtask
    initial begin
        for (int i = 0; i < 1440; i++) mem[i] = 5'd0;
        repeat (3) step(0, 0, 0, 0, 0, 1, 1);
        // Zero-filled RAM: no pixel may ever light.
        for (int i = 0; i < 2000; i++) px_at($urandom_range(639), $urandom_range(479));
        for (int y = 436; y < 474; y++) px_at(310 + y % 20, y);
        // Directed origin / far corner / just outside.
        flush();
        mem[0] = 5'd3; mem[719] = 5'b11101;
        new_frame(100, 200, 1);
        px_at(100, 200); px_at(123, 229); px_at(124, 229); px_at(99, 200); px_at(100, 230);
        for (int y = 198; y < 232; y++) for (int x = 98; x < 126; x++) px_at(x, y);
        // Edge clip at the bottom-right corner.
        fill_random();
        new_frame(630, 470, 1);
        for (int y = 466; y < 480; y++) for (int x = 626; x < 640; x++) px_at(x, y);
        px_at(639, 479); px_at(640, 479); px_at(639, 480);
        // Tearing: pos changes without frame_start must not move the box.
        new_frame(100, 200, 1);
        for (int x = 96; x < 128; x++) step(x, 210, 0, 300, 200, 1, 0);
        for (int x = 296; x < 328; x++) step(x, 210, 0, 300, 200, 1, 0);
        step(110, 210, 1, 300, 200, 1, 0);
        px_at(110, 210); px_at(310, 210);
        // Invisible sprite.
        new_frame(100, 200, 0);
        for (int i = 0; i < 500; i++) px_at($urandom_range(90, 130), $urandom_range(195, 235));
        // Animation steps: origin read across 18 frame_start pulses.
        for (int k = 0; k < 18; k++) begin new_frame(100, 200, 1); px_at(100, 200); end
        // Reset mid-scan.
        px_at(110, 210); px_at(111, 210);
        step(112, 210, 0, 0, 0, 1, 1);
        px_at(310, 445); px_at(100, 200);
        // Randomised traffic.
        fill_random();
        for (int i = 0; i < 20000; i++) begin
            int r, x, y;
            r = $urandom_range(999);
            if (r < 2) step(sx, sy, 0, 0, 0, 1, 1);
            else if (r < 6)
                step($urandom_range(1023), $urandom_range(1023), 1,
                     ($urandom % 5 == 0) ? $urandom_range(1023) : $urandom_range(639),
                     ($urandom % 5 == 0) ? $urandom_range(1023) : $urandom_range(479),
                     $urandom % 5 != 0, 0);
            else begin
                if ($urandom % 2 == 0) begin
                    x = $urandom_range(1023); y = $urandom_range(1023);
                end else begin
                    x = sx - 2 + $urandom_range(SPR_W + 3);
                    y = sy - 2 + $urandom_range(SPR_H + 3);
                    x = x < 0 ? 0 : (x > 1023 ? 1023 : x);
                    y = y < 0 ? 0 : (y > 1023 ? 1023 : y);
                end
                px_at(x, y);
            end
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
